// File: rtl/turno_ctrl_if.sv
// Cell-array bus of the memory-pairs board.
// The master side (turno_ctrl) takes the timing strobe, player picks and the
// cell labels, and drives the per-cell select/par vectors plus game status.
//   tick        timing strobe, one cycle
//   pick_valid  pick request, one-cycle pulse
//   pick_idx    index of the picked cell
//   labels      cell labels, cell i = labels[4i+3:4i]
//   select      per-cell face-up request (level)
//   par         per-cell matched flag (sticky)
//   player      player whose turn it is
//   score0/1    pairs found by each player
//   busy        picks are ignored this cycle
//   game_over   all pairs matched
//   winner      01 p0, 10 p1, 11 tie (valid with game_over)
interface turno_ctrl_if #(
  parameter int N_CELLS = 16
);
  localparam int IW = $clog2(N_CELLS);
  localparam int SW = $clog2(N_CELLS / 2 + 1);

  logic                   tick;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [4*N_CELLS-1:0]   labels;
  logic [N_CELLS-1:0]     select;
  logic [N_CELLS-1:0]     par;
  logic                   player;
  logic [SW-1:0]          score0;
  logic [SW-1:0]          score1;
  logic                   busy;
  logic                   game_over;
  logic [1:0]             winner;

  modport master (
    input  tick, pick_valid, pick_idx, labels,
    output select, par, player, score0, score1, busy, game_over, winner
  );

  modport slave (
    output tick, pick_valid, pick_idx, labels,
    input  select, par, player, score0, score1, busy, game_over, winner
  );
endinterface

// File: rtl/turno_ctrl.sv
// Turn/pair controller for the memory-pairs board (initiator of the cell bus).
// Accepts picks, turns cards face-up, compares the two labels, scores a match,
// holds a miss face-up for SHOW_TICKS ticks, passes the turn on a miss or after
// TURN_TICKS idle ticks, and flags end of game with the winner.
//   clk_Temp  system clock, rising edge
//   rst       asynchronous reset, active-low
//   bus       turno_ctrl_if master modport (picks/labels in, cell vectors and
//             game status out)
module turno_ctrl #(
  parameter int N_CELLS    = 16,
  parameter int SHOW_TICKS = 2,
  parameter int TURN_TICKS = 10
) (
  input  logic          clk_Temp,
  input  logic          rst,
  turno_ctrl_if.master  bus
);

  localparam int IW   = $clog2(N_CELLS);
  localparam int SW   = $clog2(N_CELLS / 2 + 1);
  localparam int NP   = N_CELLS / 2;
  localparam int TMAX = (TURN_TICKS > SHOW_TICKS) ? TURN_TICKS : SHOW_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [IW:0]        N_LIM = (IW + 1)'(N_CELLS);
  localparam logic [N_CELLS-1:0] ONE   = N_CELLS'(1);

  typedef enum logic [2:0] {
    S_WAIT1, S_WAIT2, S_CMP, S_MATCH, S_SHOW, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        a_q, a_d;
  logic [IW-1:0]        b_q, b_d;
  logic [N_CELLS-1:0]   select_q, select_d;
  logic [N_CELLS-1:0]   par_q, par_d;
  logic                 player_q, player_d;
  logic [SW-1:0]        score0_q, score0_d;
  logic [SW-1:0]        score1_q, score1_d;
  logic [1:0]           winner_q, winner_d;

  // Decoded conditions shared by the next-state and datapath logic.
  logic                 busy_c;
  logic                 game_over_c;
  logic                 pick_ok;
  logic                 turn_tmo;
  logic                 show_end;
  logic                 labels_eq;
  logic                 all_par;
  logic [N_CELLS-1:0]   pair_mask;
  logic [N_CELLS-1:0]   pick_mask;
  logic [SW-1:0]        score0_inc;
  logic [SW-1:0]        score1_inc;

  always_comb begin
    pick_mask = ONE << bus.pick_idx;
    pair_mask = (ONE << a_q) | (ONE << b_q);
    // The second pick must differ from the first; matched cells are dead.
    pick_ok   = bus.pick_valid && !busy_c
             && ({1'b0, bus.pick_idx} < N_LIM)
             && !par_q[bus.pick_idx]
             && !((state_q == S_WAIT2) && (bus.pick_idx == a_q));
    turn_tmo  = bus.tick && (timer_q == TW'(TURN_TICKS - 1));
    show_end  = bus.tick && (timer_q == TW'(SHOW_TICKS - 1));
    labels_eq = bus.labels[int'(a_q)*4 +: 4] == bus.labels[int'(b_q)*4 +: 4];
    all_par   = &(par_q | pair_mask);
    score0_inc = score0_q;
    score1_inc = score1_q;
    if (!player_q) begin
      if (score0_q < SW'(NP)) score0_inc = score0_q + SW'(1);
    end else begin
      if (score1_q < SW'(NP)) score1_inc = score1_q + SW'(1);
    end
  end

  // State register.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of process order.
  always_ff @(posedge clk_Temp or negedge rst) begin
    if (!rst) state_q <= S_WAIT1;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT1: if (pick_ok) state_d = S_WAIT2;
      S_WAIT2: begin
        if (pick_ok)       state_d = S_CMP;
        else if (turn_tmo) state_d = S_WAIT1;
      end
      S_CMP:   state_d = labels_eq ? S_MATCH : S_SHOW;
      S_MATCH: state_d = all_par ? S_DONE : S_WAIT1;
      S_SHOW:  if (show_end) state_d = S_WAIT1;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WAIT1;
    endcase
  end

  // Datapath next values.
  // NOTE: every *_d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    timer_d  = timer_q;
    a_d      = a_q;
    b_d      = b_q;
    select_d = select_q;
    par_d    = par_q;
    player_d = player_q;
    score0_d = score0_q;
    score1_d = score1_q;
    winner_d = winner_q;
    unique case (state_q)
      S_WAIT1, S_WAIT2: begin
        // A pick beats a concurrent tick or timeout.
        if (pick_ok) begin
          select_d = select_q | pick_mask;
          timer_d  = '0;
          if (state_q == S_WAIT1) a_d = bus.pick_idx;
          else                    b_d = bus.pick_idx;
        end else if (turn_tmo) begin
          select_d = '0;
          player_d = ~player_q;
          timer_d  = '0;
        end else if (bus.tick) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CMP: timer_d = '0;
      S_MATCH: begin
        timer_d  = '0;
        par_d    = par_q | pair_mask;
        select_d = select_q & ~pair_mask;
        score0_d = score0_inc;
        score1_d = score1_inc;
        if (all_par) begin
          select_d = '0;
          if (score0_inc > score1_inc)      winner_d = 2'b01;
          else if (score1_inc > score0_inc) winner_d = 2'b10;
          else                              winner_d = 2'b11;
        end
      end
      S_SHOW: begin
        if (show_end) begin
          select_d = select_q & ~pair_mask;
          player_d = ~player_q;
          timer_d  = '0;
        end else if (bus.tick) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: select_d = '0;
      default: ;
    endcase
  end

  // Datapath registers; reset drops any face-up cards immediately.
  always_ff @(posedge clk_Temp or negedge rst) begin
    if (!rst) begin
      timer_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      select_q <= '0;
      par_q    <= '0;
      player_q <= 1'b0;
      score0_q <= '0;
      score1_q <= '0;
      winner_q <= 2'b00;
    end else begin
      timer_q  <= timer_d;
      a_q      <= a_d;
      b_q      <= b_d;
      select_q <= select_d;
      par_q    <= par_d;
      player_q <= player_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      winner_q <= winner_d;
    end
  end

  // Output decode.
  always_comb begin
    busy_c      = (state_q == S_CMP) || (state_q == S_MATCH)
               || (state_q == S_SHOW) || (state_q == S_DONE);
    game_over_c = (state_q == S_DONE);
  end

  assign bus.select    = select_q;
  assign bus.par       = par_q;
  assign bus.player    = player_q;
  assign bus.score0    = score0_q;
  assign bus.score1    = score1_q;
  assign bus.busy      = busy_c;
  assign bus.game_over = game_over_c;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_turno_ctrl.sv
// Self-checking bench for turno_ctrl: a game-level model (face-up list,
// compare pipeline stage, tick counter) is compared against the DUT on every
// falling edge, and literal expectations pin key points of each scenario.
module tb_turno_ctrl;

  localparam int N   = 16;
  localparam int NP  = N / 2;
  localparam int SHT = 2;
  localparam int TRT = 10;

  logic clk_Temp = 1'b0;
  logic rst      = 1'b0;

  int checks   = 0;
  int failures = 0;

  turno_ctrl_if #(.N_CELLS(N)) bus ();

  turno_ctrl #(.N_CELLS(N), .SHOW_TICKS(SHT), .TURN_TICKS(TRT)) dut (
    .clk_Temp (clk_Temp),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_Temp = ~clk_Temp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int          up[$];        // face-up cells of the current turn
  int          stage;        // 0: pair just completed, 1: outcome known
  bit          is_match;
  int          ticks;
  bit [N-1:0]  m_par;
  bit          m_player;
  int          m_s0, m_s1;
  bit          m_over;
  logic [1:0]  m_win;

  function automatic logic [3:0] lab(input int i);
    return bus.labels[i*4 +: 4];
  endfunction

  task automatic model_reset();
    up.delete();
    stage = 0; is_match = 0; ticks = 0;
    m_par = '0; m_player = 0; m_s0 = 0; m_s1 = 0; m_over = 0; m_win = 2'b00;
  endtask

  task automatic model_step();
    int  idx;
    bit  valid;
    if (m_over) return;
    if (up.size() == 2) begin
      if (stage == 0) begin
        stage = 1; ticks = 0;
        is_match = (lab(up[0]) == lab(up[1]));
      end else if (is_match) begin
        m_par[up[0]] = 1'b1; m_par[up[1]] = 1'b1;
        up.delete(); ticks = 0;
        if (!m_player) m_s0 = (m_s0 < NP) ? m_s0 + 1 : m_s0;
        else           m_s1 = (m_s1 < NP) ? m_s1 + 1 : m_s1;
        if (&m_par) begin
          m_over = 1;
          m_win  = (m_s0 > m_s1) ? 2'b01 : (m_s1 > m_s0) ? 2'b10 : 2'b11;
        end
      end else if (bus.tick) begin
        ticks++;
        if (ticks == SHT) begin up.delete(); m_player = ~m_player; ticks = 0; end
      end
    end else begin
      idx   = int'(bus.pick_idx);
      valid = bus.pick_valid && idx < N && !m_par[idx]
              && !(up.size() == 1 && up[0] == idx);
      if (valid) begin
        up.push_back(idx); ticks = 0; stage = 0;
      end else if (bus.tick) begin
        ticks++;
        if (ticks == TRT) begin up.delete(); m_player = ~m_player; ticks = 0; end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_select();
    logic [N-1:0] s = '0;
    if (!m_over) foreach (up[i]) s[up[i]] = 1'b1;
    return s;
  endfunction

  always @(posedge clk_Temp or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_Temp) begin
    if (rst) begin
      check("select",    bus.select,    exp_select());
      check("par",       bus.par,       m_par);
      check("player",    bus.player,    m_player);
      check("score0",    bus.score0,    m_s0);
      check("score1",    bus.score1,    m_s1);
      check("busy",      bus.busy,      (up.size() == 2) || m_over);
      check("game_over", bus.game_over, m_over);
      check("winner",    bus.winner,    m_win);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk_Temp); #1; end
  endtask

  task automatic pick(input int idx);
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 4'(idx);
    idle(1);
    bus.pick_valid = 1'b0;
  endtask

  task automatic pick_tick(input int idx);
    bus.tick = 1'b1;
    pick(idx);
    bus.tick = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    idle(1);
    bus.tick = 1'b0;
  endtask

  task automatic match_pair(input int a, input int b);
    pick(a); pick(b); idle(2);
  endtask

  task automatic miss_pair(input int a, input int b);
    pick(a); pick(b); idle(1); tick_pulse(); tick_pulse();
  endtask

  // Watchdog: the scenario is a fixed cycle count, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pairs: (0,5)=3 (1,4)=0 (2,6)=1 (3,7)=2 (8,9)=4 (10,11)=5 (12,13)=6 (14,15)=7
    logic [3:0] lv [N] = '{4'h3, 4'h0, 4'h1, 4'h2, 4'h0, 4'h3, 4'h1, 4'h2,
                            4'h4, 4'h4, 4'h5, 4'h5, 4'h6, 4'h6, 4'h7, 4'h7};
    for (int i = 0; i < N; i++) bus.labels[i*4 +: 4] = lv[i];
    bus.tick = 1'b0; bus.pick_valid = 1'b0; bus.pick_idx = '0;

    // 1. Reset state
    idle(2);
    rst = 1'b1;
    idle(2);
    check("rst_select", bus.select, 16'h0000);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_player", bus.player, 1'b0);

    // 2. Match 0/5 by player 0
    pick(0);
    check("pick0_select", bus.select, 16'h0001);
    pick(5);
    check("cmp_busy", bus.busy, 1'b1);
    idle(2);
    check("match_par",    bus.par,    16'h0021);
    check("match_select", bus.select, 16'h0000);
    check("match_score0", bus.score0, 4'd1);
    check("match_player", bus.player, 1'b0);

    // 3. Miss 1/2: cards stay up for two ticks
    pick(1); pick(2); idle(1);
    check("show_select", bus.select, 16'h0006);
    tick_pulse();
    check("show_tick1", bus.select, 16'h0006);
    tick_pulse();
    check("show_down",   bus.select, 16'h0000);
    check("show_player", bus.player, 1'b1);

    // 4. Timeout after ten idle ticks, then a pick on the tenth tick
    pick(3);
    repeat (TRT - 1) tick_pulse();
    check("tmo_pre_select", bus.select, 16'h0008);
    tick_pulse();
    check("tmo_select", bus.select, 16'h0000);
    check("tmo_player", bus.player, 1'b0);
    pick(3);
    repeat (TRT - 1) tick_pulse();
    pick_tick(4);
    check("race_select", bus.select, 16'h0018);
    check("race_player", bus.player, 1'b0);
    idle(1); tick_pulse(); tick_pulse();
    check("race_show_player", bus.player, 1'b1);

    // 5. Rejected picks (player 1)
    pick(0);
    check("rej_matched", bus.select, 16'h0000);
    pick(1);
    pick(1);
    check("rej_same",      bus.select, 16'h0002);
    check("rej_same_busy", bus.busy,   1'b0);
    pick(2);
    pick(4);
    check("rej_busy_cmp", bus.select, 16'h0006);
    pick(4);
    check("rej_busy_show", bus.select, 16'h0006);
    tick_pulse(); tick_pulse();
    check("rej_player", bus.player, 1'b0);

    // 6. Finish the board 4:4
    match_pair(1, 4); match_pair(2, 6); match_pair(3, 7);
    miss_pair(8, 10);
    match_pair(8, 9); match_pair(10, 11); match_pair(12, 13); match_pair(14, 15);
    check("end_over",   bus.game_over, 1'b1);
    check("end_winner", bus.winner,    2'b11);
    check("end_par",    bus.par,       16'hFFFF);
    check("end_score0", bus.score0,    4'd4);
    check("end_score1", bus.score1,    4'd4);
    pick(0); tick_pulse(); idle(1);
    check("end_hold_select", bus.select,    16'h0000);
    check("end_hold_over",   bus.game_over, 1'b1);

    // 1b. Asynchronous reset during SHOW
    rst = 1'b0; idle(1); rst = 1'b1; idle(1);
    pick(1); pick(2); idle(1);
    check("pre_async_select", bus.select, 16'h0006);
    #2 rst = 1'b0;
    #1;
    check("async_select", bus.select, 16'h0000);
    check("async_busy",   bus.busy,   1'b0);
    check("async_par",    bus.par,    16'h0000);
    @(negedge clk_Temp); #1;
    rst = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
